// File: rtl/vdp_vram_pkg.sv
// rtl/vdp_vram_pkg.sv - shared encodings and default timing for the VRAM arbiter
// Contents:
//   owner_e : which requester owns the single outstanding SDRAM read
//   state_e : arbiter top-level state
//   DEF_*   : default timing for an 85.90908 MHz clock
package vdp_vram_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam int DEF_SLOT_CYCLES      = 8;
  localparam int DEF_REFRESH_INTERVAL = 1280;  // ~14.9 us at 85.90908 MHz
  localparam int DEF_STARVE_LIMIT     = 4;

endpackage

// File: rtl/vdp_vram_arbiter_if.sv
// rtl/vdp_vram_arbiter_if.sv - VRAM requester and SDRAM command bus bundle
// Ports (slave = arbiter view):
//   sdram_init_busy                                   in
//   disp_address/disp_valid -> disp_ready             display read request
//   disp_rdata/disp_rdata_en                          display read return
//   cpu_address/write/valid/wdata/wdata_mask -> ready CPU request
//   cpu_rdata/cpu_rdata_en                            CPU read return
//   sdram_address/valid/write/refresh/wdata/mask      command to ip_sdram
//   sdram_rdata/sdram_rdata_en                        read data from ip_sdram
interface vdp_vram_arbiter_if;
  logic        sdram_init_busy;
  logic [20:0] disp_address;
  logic        disp_valid;
  logic        disp_ready;
  logic [31:0] disp_rdata;
  logic        disp_rdata_en;
  logic [20:0] cpu_address;
  logic        cpu_write;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_wdata_mask;
  logic [31:0] cpu_rdata;
  logic        cpu_rdata_en;
  logic [20:0] sdram_address;
  logic        sdram_valid;
  logic        sdram_write;
  logic        sdram_refresh;
  logic [31:0] sdram_wdata;
  logic [3:0]  sdram_wdata_mask;
  logic [31:0] sdram_rdata;
  logic        sdram_rdata_en;

  modport slave (
    input  sdram_init_busy, disp_address, disp_valid, cpu_address, cpu_write,
           cpu_valid, cpu_wdata, cpu_wdata_mask, sdram_rdata, sdram_rdata_en,
    output disp_ready, disp_rdata, disp_rdata_en, cpu_ready, cpu_rdata,
           cpu_rdata_en, sdram_address, sdram_valid, sdram_write, sdram_refresh,
           sdram_wdata, sdram_wdata_mask
  );

  modport master (
    output sdram_init_busy, disp_address, disp_valid, cpu_address, cpu_write,
           cpu_valid, cpu_wdata, cpu_wdata_mask, sdram_rdata, sdram_rdata_en,
    input  disp_ready, disp_rdata, disp_rdata_en, cpu_ready, cpu_rdata,
           cpu_rdata_en, sdram_address, sdram_valid, sdram_write, sdram_refresh,
           sdram_wdata, sdram_wdata_mask
  );
endinterface

// File: rtl/vdp_vram_refresh_timer.sv
// rtl/vdp_vram_refresh_timer.sv - refresh interval counter with saturating pending count
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   enable         : counter runs only while high
//   dec            : a refresh was granted this cycle
//   pending_count  : refreshes owed, 0..3
module vdp_vram_refresh_timer
  import vdp_vram_pkg::*;
#(
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       dec,
  output logic [1:0] pending_count
);
  localparam int CNT_W = $clog2(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_INTERVAL - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pend_q, pend_d;
  logic             wrap;
  logic             take;

  assign wrap = enable && (cnt_q == CNT_LAST);
  assign take = dec && (pend_q != 2'd0);

  always_comb begin
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (enable) cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    // A wrap coinciding with a granted refresh leaves the count untouched,
    // even at saturation.
    if (wrap && !take && (pend_q != 2'd3)) pend_d = pend_q + 2'd1;
    else if (take && !wrap)                pend_d = pend_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      pend_q <= 2'd0;
    end else begin
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

  assign pending_count = pend_q;
endmodule

// File: rtl/vdp_vram_arbiter.sv
// rtl/vdp_vram_arbiter.sv - slot-based arbiter of display, CPU and refresh onto ip_sdram
// Ports:
//   clk   : system clock (85.90908 MHz)
//   reset : synchronous active-high reset
//   bus   : requester / SDRAM bundle, slave modport (see vdp_vram_arbiter_if)
module vdp_vram_arbiter
  import vdp_vram_pkg::*;
#(
  parameter int SLOT_CYCLES      = DEF_SLOT_CYCLES,
  parameter int REFRESH_INTERVAL = DEF_REFRESH_INTERVAL,
  parameter int STARVE_LIMIT     = DEF_STARVE_LIMIT
) (
  input logic               clk,
  input logic               reset,
  vdp_vram_arbiter_if.slave bus
);
  localparam int SLOT_W   = $clog2(SLOT_CYCLES + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [SLOT_W-1:0]   SLOT_LOAD  = SLOT_W'(SLOT_CYCLES - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic        sdram_valid_q, sdram_valid_d;
  logic        sdram_refresh_q, sdram_refresh_d;
  logic        sdram_write_q, sdram_write_d;
  logic [20:0] sdram_address_q, sdram_address_d;
  logic [31:0] sdram_wdata_q, sdram_wdata_d;
  logic [3:0]  sdram_wdata_mask_q, sdram_wdata_mask_d;
  logic        disp_ready_q, disp_ready_d;
  logic        cpu_ready_q, cpu_ready_d;
  logic [31:0] disp_rdata_q, disp_rdata_d;
  logic        disp_rdata_en_q, disp_rdata_en_d;
  logic [31:0] cpu_rdata_q, cpu_rdata_d;
  logic        cpu_rdata_en_q, cpu_rdata_en_d;

  logic [1:0] ref_count;
  logic       ref_pending;
  logic       slot_open;
  logic       read_free;
  logic       disp_elig;
  logic       cpu_elig;
  logic       grant_ref;
  logic       grant_cpu_starved;
  logic       grant_disp;
  logic       grant_cpu;

  vdp_vram_refresh_timer #(
    .REFRESH_INTERVAL (REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk           (clk),
    .reset         (reset),
    .enable        (state_q != ST_INIT),
    .dec           (grant_ref),
    .pending_count (ref_count)
  );

  assign ref_pending = (ref_count != 2'd0);
  assign slot_open   = (state_q == ST_IDLE) && !bus.sdram_init_busy && (slot_q == '0);
  // Only one read may be in flight, so reads wait until the owner is released.
  assign read_free   = (owner_q == OWN_NONE);
  assign disp_elig   = bus.disp_valid && read_free;
  assign cpu_elig    = bus.cpu_valid && (bus.cpu_write || read_free);

  assign grant_ref         = slot_open && ref_pending;
  assign grant_cpu_starved = slot_open && !ref_pending && cpu_elig && (starve_q == STARVE_MAX);
  assign grant_disp        = slot_open && !ref_pending && !grant_cpu_starved && disp_elig;
  assign grant_cpu         = grant_cpu_starved ||
                             (slot_open && !ref_pending && !disp_elig && cpu_elig);

  always_comb begin
    state_d            = state_q;
    owner_d            = owner_q;
    slot_d             = slot_q;
    starve_d           = starve_q;
    sdram_valid_d      = 1'b0;
    sdram_refresh_d    = 1'b0;
    sdram_write_d      = sdram_write_q;
    sdram_address_d    = sdram_address_q;
    sdram_wdata_d      = sdram_wdata_q;
    sdram_wdata_mask_d = sdram_wdata_mask_q;
    disp_ready_d       = 1'b0;
    cpu_ready_d        = 1'b0;
    disp_rdata_d       = disp_rdata_q;
    disp_rdata_en_d    = 1'b0;
    cpu_rdata_d        = cpu_rdata_q;
    cpu_rdata_en_d     = 1'b0;

    case (state_q)
      ST_INIT: if (!bus.sdram_init_busy) state_d = ST_IDLE;
      ST_IDLE: if (bus.sdram_init_busy)  state_d = ST_INIT;
      default: state_d = ST_INIT;
    endcase

    if (slot_q != '0) slot_d = slot_q - SLOT_W'(1);

    // Read return is routed regardless of state; data with no owner is dropped.
    if (bus.sdram_rdata_en && (owner_q != OWN_NONE)) begin
      if (owner_q == OWN_DISP) begin
        disp_rdata_d    = bus.sdram_rdata;
        disp_rdata_en_d = 1'b1;
      end else begin
        cpu_rdata_d    = bus.sdram_rdata;
        cpu_rdata_en_d = 1'b1;
      end
      owner_d = OWN_NONE;
    end

    if (grant_ref) begin
      sdram_refresh_d = 1'b1;
      sdram_write_d   = 1'b0;
      slot_d          = SLOT_LOAD;
    end else if (grant_disp) begin
      sdram_valid_d   = 1'b1;
      sdram_write_d   = 1'b0;
      sdram_address_d = bus.disp_address;
      disp_ready_d    = 1'b1;
      owner_d         = OWN_DISP;
      slot_d          = SLOT_LOAD;
    end else if (grant_cpu) begin
      sdram_valid_d      = 1'b1;
      sdram_write_d      = bus.cpu_write;
      sdram_address_d    = bus.cpu_address;
      sdram_wdata_d      = bus.cpu_wdata;
      sdram_wdata_mask_d = bus.cpu_wdata_mask;
      cpu_ready_d        = 1'b1;
      if (!bus.cpu_write) owner_d = OWN_CPU;
      slot_d = SLOT_LOAD;
    end

    if (!bus.cpu_valid || grant_cpu)                  starve_d = '0;
    else if (grant_disp && (starve_q != STARVE_MAX))  starve_d = starve_q + STARVE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_INIT;
      owner_q            <= OWN_NONE;
      slot_q             <= '0;
      starve_q           <= '0;
      sdram_valid_q      <= 1'b0;
      sdram_refresh_q    <= 1'b0;
      sdram_write_q      <= 1'b0;
      sdram_address_q    <= '0;
      sdram_wdata_q      <= '0;
      sdram_wdata_mask_q <= '0;
      disp_ready_q       <= 1'b0;
      cpu_ready_q        <= 1'b0;
      disp_rdata_q       <= '0;
      disp_rdata_en_q    <= 1'b0;
      cpu_rdata_q        <= '0;
      cpu_rdata_en_q     <= 1'b0;
    end else begin
      state_q            <= state_d;
      owner_q            <= owner_d;
      slot_q             <= slot_d;
      starve_q           <= starve_d;
      sdram_valid_q      <= sdram_valid_d;
      sdram_refresh_q    <= sdram_refresh_d;
      sdram_write_q      <= sdram_write_d;
      sdram_address_q    <= sdram_address_d;
      sdram_wdata_q      <= sdram_wdata_d;
      sdram_wdata_mask_q <= sdram_wdata_mask_d;
      disp_ready_q       <= disp_ready_d;
      cpu_ready_q        <= cpu_ready_d;
      disp_rdata_q       <= disp_rdata_d;
      disp_rdata_en_q    <= disp_rdata_en_d;
      cpu_rdata_q        <= cpu_rdata_d;
      cpu_rdata_en_q     <= cpu_rdata_en_d;
    end
  end

  assign bus.sdram_valid      = sdram_valid_q;
  assign bus.sdram_refresh    = sdram_refresh_q;
  assign bus.sdram_write      = sdram_write_q;
  assign bus.sdram_address    = sdram_address_q;
  assign bus.sdram_wdata      = sdram_wdata_q;
  assign bus.sdram_wdata_mask = sdram_wdata_mask_q;
  assign bus.disp_ready       = disp_ready_q;
  assign bus.cpu_ready        = cpu_ready_q;
  assign bus.disp_rdata       = disp_rdata_q;
  assign bus.disp_rdata_en    = disp_rdata_en_q;
  assign bus.cpu_rdata        = cpu_rdata_q;
  assign bus.cpu_rdata_en     = cpu_rdata_en_q;
endmodule
